// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over a
// req/ack memory handshake and hands it to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              id_ready,
  output logic [31:0]       if_instr,
  output logic [5:0]        if_opcode,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [ADDR_W-1:0] PcInc     = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ifPc_q, ifPc_d;
  logic [ADDR_W-1:0] ifPcPlus4_q, ifPcPlus4_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pcNext;

  // Sequential increment wraps naturally at the top of the address space.
  assign pcNext = pc_q + PcInc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      ifPc_q      <= '0;
      ifPcPlus4_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      ifPc_q      <= ifPc_d;
      ifPcPlus4_q <= ifPcPlus4_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    ifPc_d      = ifPc_q;
    ifPcPlus4_d = ifPcPlus4_q;
    valid_d     = valid_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d     = imem_rdata;
          ifPc_d      = pc_q;
          ifPcPlus4_d = pcNext;
          valid_d     = 1'b1;
          pc_d        = pcNext;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (id_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A redirect squashes both the in-flight fetch and any held instruction.
    if (redirect) begin
      pc_d    = redirect_pc & AlignMask;
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_opcode   = instr_q[31:26];
  assign if_pc       = ifPc_q;
  assign if_pc_plus4 = ifPcPlus4_q;

endmodule
